// File: rtl/uart_mmio.sv
// Memory-mapped bridge between the load/store bus and a UART TX/RX pair.
// TX bytes queue in a FIFO drained by a small handshake FSM; RX bytes are captured into a FIFO.

module uart_mmio_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic [W-1:0] i_din,
    input  logic         i_pop,
    output logic [W-1:0] o_head,
    output logic         o_full,
    output logic         o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]  r_wptr;
    logic [AW:0]  r_rptr;
    logic [W-1:0] r_mem [DEPTH];
    logic         w_do_pop;
    logic         w_do_push;

    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_do_pop  = i_pop & ~o_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_head    = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + PTR_ONE;
            if (w_do_pop)  r_rptr <= r_rptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_din;
    end
endmodule

module uart_mmio #(
    parameter int TX_DEPTH = 8,
    parameter int RX_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  addr,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        rdata_vld,
    output logic        irq,
    output logic        trmt,
    output logic [7:0]  tx_data,
    input  logic        tx_done,
    input  logic        rx_rdy,
    input  logic [7:0]  rx_data,
    output logic        clr_rx_rdy
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_GUARD, S_WAIT} tx_state_t;

    localparam logic [1:0] A_DATA   = 2'd0;
    localparam logic [1:0] A_STATUS = 2'd1;
    localparam logic [1:0] A_CTRL   = 2'd2;

    tx_state_t   r_state;
    tx_state_t   w_next;
    logic [7:0]  r_tx_data;
    logic [31:0] r_rdata;
    logic        r_rdata_vld;
    logic        r_irq;
    logic        r_clr_rx_rdy;
    logic        r_rx_rdy_q;
    logic        r_tx_drop;
    logic        r_rx_ovf;
    logic [1:0]  r_ctrl;

    logic        w_tx_push, w_tx_pop, w_tx_full, w_tx_empty;
    logic [7:0]  w_tx_head;
    logic        w_rx_push, w_rx_pop, w_rx_full, w_rx_empty;
    logic [7:0]  w_rx_head;
    logic        w_wr_data, w_wr_status, w_wr_ctrl, w_rd_data;
    logic        w_tx_busy;
    logic        w_cap;
    logic [31:0] w_status;
    logic [31:0] w_rd_val;
    logic        w_unused;

    assign w_wr_data   = wr_en & (addr == A_DATA);
    assign w_wr_status = wr_en & (addr == A_STATUS);
    assign w_wr_ctrl   = wr_en & (addr == A_CTRL);
    assign w_rd_data   = rd_en & (addr == A_DATA);
    assign w_unused    = ^wdata[31:8];

    assign w_tx_push = w_wr_data;
    assign w_cap     = rx_rdy & ~r_rx_rdy_q;
    assign w_rx_push = w_cap;
    assign w_rx_pop  = w_rd_data;
    assign w_tx_busy = (r_state != S_IDLE);

    uart_mmio_fifo #(.DEPTH(TX_DEPTH), .W(8)) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_tx_push),
        .i_din   (wdata[7:0]),
        .i_pop   (w_tx_pop),
        .o_head  (w_tx_head),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty)
    );

    uart_mmio_fifo #(.DEPTH(RX_DEPTH), .W(8)) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_rx_push),
        .i_din   (rx_data),
        .i_pop   (w_rx_pop),
        .o_head  (w_rx_head),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // GUARD exists so a tx_done left high from the previous byte is never taken as completion.
    always_comb begin
        w_next   = r_state;
        w_tx_pop = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_tx_empty) begin
                    w_tx_pop = 1'b1;
                    w_next   = S_LOAD;
                end
            end
            S_LOAD:  w_next = S_GUARD;
            S_GUARD: w_next = S_WAIT;
            S_WAIT:  if (tx_done) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)           r_tx_data <= 8'h00;
        else if (w_tx_pop) r_tx_data <= w_tx_head;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_rdy_q   <= 1'b0;
            r_clr_rx_rdy <= 1'b0;
        end else begin
            r_rx_rdy_q   <= rx_rdy;
            r_clr_rx_rdy <= w_cap;
        end
    end

    // Sticky flags: a new error event in the same cycle as a clear wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_drop <= 1'b0;
            r_rx_ovf  <= 1'b0;
            r_ctrl    <= 2'b00;
        end else begin
            if (w_wr_status && wdata[5]) r_tx_drop <= 1'b0;
            if (w_wr_status && wdata[4]) r_rx_ovf  <= 1'b0;
            if (w_wr_data && w_tx_full && !w_tx_pop) r_tx_drop <= 1'b1;
            if (w_cap && w_rx_full && !w_rd_data)    r_rx_ovf  <= 1'b1;
            if (w_wr_ctrl) r_ctrl <= wdata[1:0];
        end
    end

    assign w_status = {26'd0, r_tx_drop, r_rx_ovf, w_tx_busy, w_tx_full, w_tx_empty, ~w_rx_empty};

    always_comb begin
        w_rd_val = 32'd0;
        case (addr)
            A_DATA:   w_rd_val = w_rx_empty ? 32'd0 : {24'd0, w_rx_head};
            A_STATUS: w_rd_val = w_status;
            A_CTRL:   w_rd_val = {30'd0, r_ctrl};
            default:  w_rd_val = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata     <= 32'd0;
            r_rdata_vld <= 1'b0;
            r_irq       <= 1'b0;
        end else begin
            r_rdata_vld <= rd_en;
            if (rd_en) r_rdata <= w_rd_val;
            r_irq <= (r_ctrl[0] & ~w_rx_empty) | (r_ctrl[1] & w_tx_empty & ~w_tx_busy);
        end
    end

    assign rdata      = r_rdata;
    assign rdata_vld  = r_rdata_vld;
    assign irq        = r_irq;
    assign trmt       = (r_state == S_LOAD);
    assign tx_data    = r_tx_data;
    assign clr_rx_rdy = r_clr_rx_rdy;
endmodule
